// File: rtl/tinst_sched.sv
// tinst_sched: in-order tile-instruction scheduler feeding the systolic-array
// single-entry issue port. Buffers up to DEPTH instructions, enforces the
// A-loaded / C-valid / array-drain hazards and drops illegal TMMAs with an
// error pulse.
// Optional build macro TSCHED_PERF_CNT_EN adds saturating performance counters.

`ifndef TINST_TYPE_WIDTH
`define TINST_TYPE_WIDTH 2
`endif
`ifndef TLOAD_DATAW_WIDTH
`define TLOAD_DATAW_WIDTH 2
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 3
`endif

module tinst_sched #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DRAIN_CYCLES = 40,
    parameter int unsigned CNT_W        = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_i,
    input  logic                             enq_valid_i,
    output logic                             enq_ready_o,
    input  logic [`TINST_TYPE_WIDTH-1:0]     enq_type_i,
    input  logic [`TLOAD_DATAW_WIDTH-1:0]    enq_data_width_i,
    input  logic [`ADDR_WIDTH-1:0]           enq_addr0_i,
    input  logic [`ADDR_WIDTH-1:0]           enq_addr1_i,
    input  logic [`TMMA_PRECISION_WIDTH-1:0] enq_precision_i,
    input  logic                             enq_acc_i,
    output logic                             issue_valid_o,
    input  logic                             issue_ready_i,
    output logic [`TINST_TYPE_WIDTH-1:0]     issue_type_o,
    output logic [`TLOAD_DATAW_WIDTH-1:0]    issue_data_width_o,
    output logic [`ADDR_WIDTH-1:0]           issue_addr0_o,
    output logic [`ADDR_WIDTH-1:0]           issue_addr1_o,
    output logic [`TMMA_PRECISION_WIDTH-1:0] issue_precision_o,
    output logic                             issue_acc_o,
    output logic                             err_o,
    output logic [1:0]                       err_code_o,
    output logic [$clog2(DEPTH):0]           q_count_o,
    output logic                             busy_o
`ifdef TSCHED_PERF_CNT_EN
    ,
    output logic [31:0]                      perf_issued_o,
    output logic [31:0]                      perf_drain_stall_o,
    output logic [31:0]                      perf_ready_stall_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [`TINST_TYPE_WIDTH-1:0] {
        TI_TMMA       = 0,
        TI_PRELOADA   = 1,
        TI_PRELOADC   = 2,
        TI_POSTSTOREC = 3
    } tinst_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_DRAIN,
        S_ERR
    } state_e;

    typedef struct packed {
        logic [`TINST_TYPE_WIDTH-1:0]     typ;
        logic [`TLOAD_DATAW_WIDTH-1:0]    dw;
        logic [`ADDR_WIDTH-1:0]           addr0;
        logic [`ADDR_WIDTH-1:0]           addr1;
        logic [`TMMA_PRECISION_WIDTH-1:0] prec;
        logic                             acc;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    state_e          state;
    state_e          state_next;
    logic            a_loaded;
    logic            c_valid;
    logic [CNT_W-1:0] drain_cnt;
    logic [1:0]      err_code;
    logic [1:0]      err_code_next;
    logic            enq;
    logic            deq;
    logic            hs;

    assign enq_ready_o = (count != CW'(DEPTH));
    assign enq         = enq_valid_i && enq_ready_o;
    assign head        = mem[rd_ptr];

    assign issue_valid_o      = (state == S_ISSUE);
    assign issue_type_o       = head.typ;
    assign issue_data_width_o = head.dw;
    assign issue_addr0_o      = head.addr0;
    assign issue_addr1_o      = head.addr1;
    assign issue_precision_o  = head.prec;
    assign issue_acc_o        = head.acc;
    assign err_o              = (state == S_ERR);
    assign err_code_o         = err_code;
    assign q_count_o          = count;
    assign busy_o             = (count != '0) || (drain_cnt != '0);

    // Queue storage: payload only, no reset needed.
    always_ff @(posedge clk) begin
        if (enq && !flush_i) begin
            mem[wr_ptr] <= '{typ:   enq_type_i,
                             dw:    enq_data_width_i,
                             addr0: enq_addr0_i,
                             addr1: enq_addr1_i,
                             prec:  enq_precision_i,
                             acc:   enq_acc_i};
        end
    end

    // Next-state, dequeue and error-code decisions for the head entry.
    always_comb begin
        state_next    = state;
        deq           = 1'b0;
        hs            = 1'b0;
        err_code_next = err_code;
        case (state)
            S_IDLE: begin
                if (count != '0) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (head.typ == TI_TMMA && !a_loaded) begin
                    state_next    = S_ERR;
                    err_code_next = 2'd1;
                end else if (head.typ == TI_TMMA && head.acc && !c_valid) begin
                    state_next    = S_ERR;
                    err_code_next = 2'd2;
                end else if (head.typ == TI_POSTSTOREC && drain_cnt != '0) begin
                    state_next = S_DRAIN;
                end else begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_ready_i) begin
                    hs         = 1'b1;
                    deq        = 1'b1;
                    state_next = (count == CW'(1) && !enq) ? S_IDLE : S_CHECK;
                end
            end
            S_DRAIN: begin
                // Leave as the counter reaches zero so POSTSTOREC is offered
                // in the first cycle the counter reads zero.
                if (drain_cnt <= CNT_W'(1)) state_next = S_ISSUE;
            end
            S_ERR: begin
                deq        = 1'b1;
                state_next = (count == CW'(1) && !enq) ? S_IDLE : S_CHECK;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control state: FSM, pointers, occupancy, hazard flags, drain counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            a_loaded  <= 1'b0;
            c_valid   <= 1'b0;
            drain_cnt <= '0;
            err_code  <= '0;
        end else if (flush_i) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            a_loaded  <= 1'b0;
            c_valid   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state    <= state_next;
            err_code <= err_code_next;
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(enq) - CW'(deq);
            if (hs) begin
                case (head.typ)
                    TI_PRELOADA:   a_loaded <= 1'b1;
                    TI_PRELOADC:   c_valid  <= 1'b1;
                    TI_TMMA:       c_valid  <= 1'b1;
                    TI_POSTSTOREC: c_valid  <= 1'b0;
                    default: ;
                endcase
            end
            if (hs && head.typ == TI_TMMA) begin
                drain_cnt <= CNT_W'(DRAIN_CYCLES);
            end else if (drain_cnt != '0) begin
                drain_cnt <= drain_cnt - CNT_W'(1);
            end
        end
    end

`ifdef TSCHED_PERF_CNT_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_drain;
    logic [31:0] perf_ready;

    // Saturating event counters; cleared by rst only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued <= '0;
            perf_drain  <= '0;
            perf_ready  <= '0;
        end else begin
            if (hs && !flush_i && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
            if (state == S_DRAIN && perf_drain != '1) perf_drain <= perf_drain + 32'd1;
            if (state == S_ISSUE && !issue_ready_i && perf_ready != '1) perf_ready <= perf_ready + 32'd1;
        end
    end

    assign perf_issued_o      = perf_issued;
    assign perf_drain_stall_o = perf_drain;
    assign perf_ready_stall_o = perf_ready;
`endif

endmodule

// File: tb/tb_tinst_sched.sv
// tb_tinst_sched: directed self-checking bench for tinst_sched.

`ifndef TINST_TYPE_WIDTH
`define TINST_TYPE_WIDTH 2
`endif
`ifndef TLOAD_DATAW_WIDTH
`define TLOAD_DATAW_WIDTH 2
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 3
`endif

module tb_tinst_sched;

    localparam logic [1:0] T_TMMA       = 2'd0;
    localparam logic [1:0] T_PRELOADA   = 2'd1;
    localparam logic [1:0] T_PRELOADC   = 2'd2;
    localparam logic [1:0] T_POSTSTOREC = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        enq_valid_i = 1'b0;
    logic        enq_ready_o;
    logic [1:0]  enq_type_i = '0;
    logic [1:0]  enq_data_width_i = '0;
    logic [31:0] enq_addr0_i = '0;
    logic [31:0] enq_addr1_i = '0;
    logic [2:0]  enq_precision_i = '0;
    logic        enq_acc_i = 1'b0;
    logic        issue_valid_o;
    logic        issue_ready_i = 1'b0;
    logic [1:0]  issue_type_o;
    logic [1:0]  issue_data_width_o;
    logic [31:0] issue_addr0_o;
    logic [31:0] issue_addr1_o;
    logic [2:0]  issue_precision_o;
    logic        issue_acc_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic [2:0]  q_count_o;
    logic        busy_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;

    int unsigned mon_hs = 0;
    int unsigned mon_err = 0;
    logic [31:0] mon_seq = '0;
    logic [1:0]  mon_code = '0;

    tinst_sched #(.DEPTH(4), .DRAIN_CYCLES(40), .CNT_W(6)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .enq_valid_i        (enq_valid_i),
        .enq_ready_o        (enq_ready_o),
        .enq_type_i         (enq_type_i),
        .enq_data_width_i   (enq_data_width_i),
        .enq_addr0_i        (enq_addr0_i),
        .enq_addr1_i        (enq_addr1_i),
        .enq_precision_i    (enq_precision_i),
        .enq_acc_i          (enq_acc_i),
        .issue_valid_o      (issue_valid_o),
        .issue_ready_i      (issue_ready_i),
        .issue_type_o       (issue_type_o),
        .issue_data_width_o (issue_data_width_o),
        .issue_addr0_o      (issue_addr0_o),
        .issue_addr1_o      (issue_addr1_o),
        .issue_precision_o  (issue_precision_o),
        .issue_acc_o        (issue_acc_o),
        .err_o              (err_o),
        .err_code_o         (err_code_o),
        .q_count_o          (q_count_o),
        .busy_o             (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake / error monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (issue_valid_o && issue_ready_i) begin
                mon_hs  <= mon_hs + 1;
                mon_seq <= {mon_seq[29:0], issue_type_o};
            end
            if (err_o) begin
                mon_err  <= mon_err + 1;
                mon_code <= err_code_o;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic push(input logic [1:0] t, input logic [1:0] dw, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [2:0] pr, input logic ac);
        automatic int unsigned n;
        n = 0;
        enq_type_i       = t;
        enq_data_width_i = dw;
        enq_addr0_i      = a0;
        enq_addr1_i      = a1;
        enq_precision_i  = pr;
        enq_acc_i        = ac;
        enq_valid_i      = 1'b1;
        while (!enq_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("push_timeout", 32'(enq_ready_o), 32'd1);
        tick();
        enq_valid_i = 1'b0;
    endtask

    function automatic logic [1:0] ent_type(input int unsigned i);
        logic [31:0] v;
        v = i;
        return v[0] ? T_PRELOADC : T_PRELOADA;
    endfunction

    task automatic push_ent(input int unsigned i);
        logic [31:0] v;
        v = i;
        push(ent_type(i), v[1:0], 32'h2000 + v, 32'h3000 + v, v[2:0], v[0]);
    endtask

    task automatic consume_ents(input int unsigned first, input int unsigned last);
        automatic int unsigned w;
        for (int unsigned k = first; k <= last; k++) begin
            w = 0;
            while (!issue_valid_o && w < 20) begin
                tick();
                w++;
            end
            check("order_valid", 32'(issue_valid_o), 32'd1);
            check("order_addr0", issue_addr0_o, 32'h2000 + k);
            check("order_type", 32'(issue_type_o), 32'(ent_type(k)));
            tick();
        end
    endtask

    task automatic produce_ents(input int unsigned first, input int unsigned last);
        for (int unsigned k = first; k <= last; k++) push_ent(k);
    endtask

    initial begin
        automatic int unsigned hs0, err0, tmma_edge, ps_edge;
        automatic logic busy_all;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_issue_valid", 32'(issue_valid_o), 32'd0);
        check("rst_enq_ready", 32'(enq_ready_o), 32'd1);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_err_code", 32'(err_code_o), 32'd0);
        check("rst_q_count", 32'(q_count_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);

        // Single PRELOADA: issue 2 cycles after the enqueue edge
        issue_ready_i = 1'b1;
        push(T_PRELOADA, 2'd2, 32'h1000, 32'h0, 3'd0, 1'b0);
        check("t1_valid_e0", 32'(issue_valid_o), 32'd0);
        check("t1_count", 32'(q_count_o), 32'd1);
        check("t1_busy", 32'(busy_o), 32'd1);
        tick();
        check("t1_valid_e1", 32'(issue_valid_o), 32'd0);
        tick();
        check("t1_valid_e2", 32'(issue_valid_o), 32'd1);
        check("t1_type", 32'(issue_type_o), 32'(T_PRELOADA));
        check("t1_addr0", issue_addr0_o, 32'h1000);
        check("t1_dw", 32'(issue_data_width_o), 32'd2);
        tick();
        check("t1_after_valid", 32'(issue_valid_o), 32'd0);
        check("t1_after_count", 32'(q_count_o), 32'd0);
        check("t1_after_busy", 32'(busy_o), 32'd0);
        check("t1_a_loaded", 32'(dut.a_loaded), 32'd1);

        // TMMA without A loaded -> error code 1, entry dropped
        flush();
        push(T_TMMA, 2'd0, 32'h10, 32'h20, 3'd1, 1'b0);
        tick();
        tick();
        check("t2_err_pulse", 32'(err_o), 32'd1);
        check("t2_err_code", 32'(err_code_o), 32'd1);
        check("t2_no_issue", 32'(issue_valid_o), 32'd0);
        tick();
        check("t2_err_end", 32'(err_o), 32'd0);
        check("t2_count", 32'(q_count_o), 32'd0);
        check("t2_code_hold", 32'(err_code_o), 32'd1);

        // PRELOADA, TMMA, POSTSTOREC: drain gap of 40 cycles
        push(T_PRELOADA, 2'd1, 32'h100, 32'h0, 3'd0, 1'b0);
        push(T_TMMA, 2'd0, 32'h200, 32'h300, 3'd2, 1'b0);
        push(T_POSTSTOREC, 2'd0, 32'h400, 32'h0, 3'd0, 1'b0);
        tmma_edge = 0;
        ps_edge = 0;
        busy_all = 1'b1;
        for (int i = 0; i < 200; i++) begin
            busy_all = busy_all & busy_o;
            if (issue_valid_o && issue_ready_i && issue_type_o == T_TMMA) tmma_edge = cyc + 1;
            if (issue_valid_o && issue_type_o == T_POSTSTOREC) begin
                ps_edge = cyc;
                break;
            end
            tick();
        end
        check("t3_drain_gap", ps_edge - tmma_edge, 32'd40);
        check("t3_busy_throughout", 32'(busy_all), 32'd1);
        check("t3_ps_addr0", issue_addr0_o, 32'h400);
        tick();
        check("t3_count", 32'(q_count_o), 32'd0);
        check("t3_busy_end", 32'(busy_o), 32'd0);
        check("t3_c_valid", 32'(dut.c_valid), 32'd0);

        // Fill with ready low, hold, then drain in order across pointer wrap
        issue_ready_i = 1'b0;
        for (int unsigned i = 0; i < 4; i++) push_ent(i);
        check("t4_full_ready", 32'(enq_ready_o), 32'd0);
        check("t4_full_count", 32'(q_count_o), 32'd4);
        enq_type_i  = T_PRELOADA;
        enq_addr0_i = 32'hDEAD;
        enq_valid_i = 1'b1;
        tick();
        enq_valid_i = 1'b0;
        check("t4_fifth_ignored", 32'(q_count_o), 32'd4);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", 32'(issue_valid_o), 32'd1);
            check("t4_hold_addr0", issue_addr0_o, 32'h2000);
            check("t4_hold_misc", {22'd0, issue_type_o, issue_data_width_o, issue_precision_o, issue_acc_o, issue_addr1_o[15:0]},
                  {22'd0, T_PRELOADA, 2'd0, 3'd0, 1'b0, 16'h3000});
            tick();
        end
        issue_ready_i = 1'b1;
        fork
            consume_ents(0, 11);
            produce_ents(4, 11);
        join
        check("t4_empty", 32'(q_count_o), 32'd0);

        // PRELOADC, POSTSTOREC, then acc TMMA -> error code 2
        flush();
        hs0 = mon_hs;
        err0 = mon_err;
        push(T_PRELOADA, 2'd0, 32'h500, 32'h0, 3'd0, 1'b0);
        push(T_PRELOADC, 2'd0, 32'h600, 32'h0, 3'd0, 1'b0);
        push(T_POSTSTOREC, 2'd0, 32'h700, 32'h0, 3'd0, 1'b0);
        push(T_TMMA, 2'd0, 32'h800, 32'h900, 3'd0, 1'b1);
        repeat (20) tick();
        check("t5_issued", mon_hs - hs0, 32'd3);
        check("t5_seq", 32'(mon_seq[5:0]), 32'h1B);
        check("t5_errs", mon_err - err0, 32'd1);
        check("t5_code", 32'(err_code_o), 32'd2);

        // TMMA acc directly after PRELOADC issues
        hs0 = mon_hs;
        err0 = mon_err;
        push(T_PRELOADC, 2'd0, 32'hA00, 32'h0, 3'd0, 1'b0);
        push(T_TMMA, 2'd0, 32'hB00, 32'hC00, 3'd3, 1'b1);
        repeat (10) tick();
        check("t5b_issued", mon_hs - hs0, 32'd2);
        check("t5b_seq", 32'(mon_seq[3:0]), 32'h8);
        check("t5b_errs", mon_err - err0, 32'd0);
        check("t5b_busy_drain", 32'(busy_o), 32'd1);

        // Flush in ISSUE with 3 queued and a simultaneous enqueue
        flush();
        push(T_PRELOADA, 2'd0, 32'hD00, 32'h0, 3'd0, 1'b0);
        repeat (6) tick();
        check("t6_a_loaded_pre", 32'(dut.a_loaded), 32'd1);
        issue_ready_i = 1'b0;
        push(T_PRELOADA, 2'd0, 32'hE00, 32'h0, 3'd0, 1'b0);
        push(T_PRELOADA, 2'd0, 32'hE01, 32'h0, 3'd0, 1'b0);
        push(T_PRELOADA, 2'd0, 32'hE02, 32'h0, 3'd0, 1'b0);
        check("t6_in_issue", 32'(issue_valid_o), 32'd1);
        check("t6_count3", 32'(q_count_o), 32'd3);
        enq_type_i  = T_TMMA;
        enq_addr0_i = 32'hF00;
        enq_acc_i   = 1'b0;
        enq_valid_i = 1'b1;
        flush_i     = 1'b1;
        tick();
        enq_valid_i = 1'b0;
        flush_i     = 1'b0;
        check("t6_valid_dropped", 32'(issue_valid_o), 32'd0);
        check("t6_count0", 32'(q_count_o), 32'd0);
        check("t6_a_cleared", 32'(dut.a_loaded), 32'd0);
        check("t6_code_kept", 32'(err_code_o), 32'd2);
        tick();
        check("t6_enq_discarded", 32'(q_count_o), 32'd0);
        issue_ready_i = 1'b1;
        hs0 = mon_hs;
        err0 = mon_err;
        push(T_TMMA, 2'd0, 32'hF10, 32'hF20, 3'd0, 1'b0);
        repeat (6) tick();
        check("t6_err_seen", mon_err - err0, 32'd1);
        check("t6_err_code1", 32'(err_code_o), 32'd1);
        check("t6_no_issue", mon_hs - hs0, 32'd0);
        check("t6_final_count", 32'(q_count_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
